// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter
//   Shares one synchronous VRAM port between the PPU fetch engine and the
//   6502 CPU. The PPU always wins and sees no added latency; CPU writes are
//   absorbed by a single-entry write buffer that drains into idle VRAM
//   cycles; CPU reads wait for a cycle with no PPU fetch and an empty buffer,
//   so a read can never overtake an earlier write.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ppu_req/ppu_addr         single-cycle PPU fetch request
//   ppu_rvalid/ppu_rdata     fetch data, one cycle after ppu_req
//   cpu_req/we/addr/wdata    CPU request, held stable until cpu_ack
//   cpu_ack/cpu_rdata        registered completion pulse and read data
//   mem_en/we/addr/wdata     VRAM port controls (combinational)
//   mem_rdata                VRAM read data, one-cycle latency
//
// Handshake: the CPU raises cpu_req with stable cpu_we/cpu_addr/cpu_wdata and
// keeps them until it sees cpu_ack high for one cycle; cpu_req is ignored
// during that ack cycle, so the CPU drops it (or presents the next request)
// after the ack cycle. A write acks as soon as it is in the buffer, not when
// it reaches VRAM.
module ppu_vram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_DATA = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                ppu_rvalid_q, ppu_rvalid_d;

  logic                rd_issue;
  logic                drain;

  always_comb begin
    // A CPU read only goes out on a cycle the PPU leaves free and after any
    // buffered write has landed, which keeps read-after-write ordering.
    rd_issue = !rst && (state_q == RD_PEND) && !ppu_req && !buf_valid_q;
    // rd_issue already requires an empty buffer, so the two never overlap.
    drain    = !rst && buf_valid_q && !ppu_req;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ppu_req) begin
      mem_en   = 1'b1;
      mem_addr = ppu_addr;
    end else if (rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr;
    end else if (drain) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = buf_addr_q;
      mem_wdata = buf_data_q;
    end

    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    cpu_rdata_d  = cpu_rdata_q;
    ppu_rvalid_d = ppu_req;

    if (drain) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            // A full buffer stalls the write in IDLE until it drains; the
            // load never shares a cycle with a drain.
            if (!buf_valid_q) begin
              buf_valid_d = 1'b1;
              buf_addr_d  = cpu_addr;
              buf_data_d  = cpu_wdata;
              state_d     = ACK;
            end
          end else begin
            state_d = RD_PEND;
          end
        end
      end
      RD_PEND: begin
        if (rd_issue) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        cpu_rdata_d = mem_rdata;
        state_d     = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      ppu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ppu_rvalid_q <= ppu_rvalid_d;
    end
  end

  assign ppu_rvalid = ppu_rvalid_q;
  assign ppu_rdata  = mem_rdata;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Testbench for ppu_vram_arbiter: table-driven PPU vectors, hand-written
// multi-cycle sequences and a randomized CPU/PPU mix checked against a
// reference memory that applies CPU writes at their ack.
module tb_ppu_vram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ppu_req;
  logic [AW-1:0] ppu_addr;
  logic          ppu_rvalid;
  logic [DW-1:0] ppu_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // clock / reset block
  always #10 clk = ~clk;

  ppu_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr),
    .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int chk = 0;
  int err = 0;
  int cyc = 0;

  // VRAM behaviour, reference memory and expected read queue
  logic [DW-1:0] vram    [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] wlog_addr [$];
  logic [DW-1:0] wlog_data [$];
  int            wlog_cyc  [$];

  // snapshot of the DUT outputs taken mid-cycle
  logic          s_en, s_we, s_ack, s_rvalid, s_ppu_req;
  logic [AW-1:0] s_addr, s_paddr;
  logic [DW-1:0] s_wdata, s_crdata, s_prdata;

  logic exp_rvalid = 1'b0;
  logic mon_en     = 1'b0;
  logic op_active  = 1'b0;
  int   last_hi    = 0;
  int   ppu_mode   = 0;   // 0 manual, 1 hold, 2 alternate, 3 random
  int   ppu_hold   = 0;
  int   ppu_pct    = 0;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic          exp_rvalid;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, run the always-on checks, then at the
  // rising edge apply the VRAM model and the PPU stimulus mode.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    s_ack = cpu_ack; s_crdata = cpu_rdata; s_rvalid = ppu_rvalid;
    s_prdata = ppu_rdata; s_ppu_req = ppu_req; s_paddr = ppu_addr;
    if (s_ppu_req) last_hi = cyc;
    if (mon_en) begin
      check("rvalid_delay", 32'(s_rvalid), 32'(exp_rvalid));
      if (s_rvalid) check("ppu_rdata_pass", 32'(s_prdata), 32'(mem_rdata));
      if (s_ppu_req) check("ppu_priority", 32'({s_en, s_we, s_addr}), 32'({1'b1, 1'b0, s_paddr}));
      if (!op_active) check("spurious_ack", 32'(s_ack), 32'(1'b0));
    end
    exp_rvalid = rst ? 1'b0 : ppu_req;
    @(posedge clk);
    #1;
    if (s_en) begin
      if (s_we) begin
        vram[s_addr] = s_wdata;
        wlog_addr.push_back(s_addr);
        wlog_data.push_back(s_wdata);
        wlog_cyc.push_back(cyc);
      end else begin
        mem_rdata = vram[s_addr];
      end
    end
    case (ppu_mode)
      1: begin
        if (ppu_hold > 0) begin
          ppu_req = 1'b1;
          ppu_addr = AW'($urandom_range(0, 2047));
          ppu_hold--;
        end else begin
          ppu_req = 1'b0;
        end
      end
      2: begin
        ppu_req = !ppu_req;
        ppu_addr = AW'($urandom_range(0, 2047));
      end
      3: begin
        ppu_req = ($urandom_range(0, 99) < ppu_pct);
        ppu_addr = AW'($urandom_range(0, 2047));
      end
      default: ;
    endcase
  endtask

  // driver: one CPU access, bounded wait for ack, scoreboard update
  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        output int start_c, output int issue_c, output int ack_c);
    logic [DW-1:0] exp;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    op_active = 1'b1;
    if (!we) exp_q.push_back(ref_mem[addr]);
    start_c = cyc + 1;
    issue_c = -1;
    ack_c = -1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (!we && s_en && !s_we && !s_ppu_req && s_addr == addr && issue_c < 0) issue_c = cyc;
      if (s_ack) begin
        ack_c = cyc;
        break;
      end
    end
    cpu_req = 1'b0;
    op_active = 1'b0;
    check("ack_seen", 32'(ack_c >= 0), 32'(1'b1));
    if (!we) exp = exp_q.pop_front();
    else exp = '0;
    if (ack_c >= 0) begin
      if (we) begin
        ref_mem[addr] = wdata;
      end else begin
        check("cpu_rdata", 32'(s_crdata), 32'(exp));
        check("rd_issue_to_ack", 32'(ack_c - issue_c), 32'd2);
      end
    end
  endtask

  initial begin
    int st, is, ak, st2, ak2, n0;
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    rst = 1'b1; ppu_req = 1'b0; ppu_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0;
    for (int a = 0; a < 2048; a++) begin
      vram[a] = init_val(AW'(a));
      ref_mem[a] = init_val(AW'(a));
    end

    tbl[0] = '{1'b0, 11'h7FF, 1'b0, 11'h000, 1'b0};
    tbl[1] = '{1'b1, 11'h000, 1'b1, 11'h000, 1'b0};
    tbl[2] = '{1'b1, 11'h7FF, 1'b1, 11'h7FF, 1'b1};
    tbl[3] = '{1'b0, 11'h155, 1'b0, 11'h000, 1'b1};
    tbl[4] = '{1'b0, 11'h2AA, 1'b0, 11'h000, 1'b0};
    tbl[5] = '{1'b1, 11'h2AA, 1'b1, 11'h2AA, 1'b0};
    tbl[6] = '{1'b0, 11'h001, 1'b0, 11'h000, 1'b1};
    tbl[7] = '{1'b1, 11'h400, 1'b1, 11'h400, 1'b0};

    // reset behaviour
    cycle();
    cycle();
    check("rst_cpu_ack", 32'(s_ack), 32'(1'b0));
    check("rst_rvalid", 32'(s_rvalid), 32'(1'b0));
    check("rst_cpu_rdata", 32'(s_crdata), 32'h0);
    check("rst_mem_en_idle", 32'(s_en), 32'(1'b0));
    ppu_req = 1'b1; ppu_addr = 11'h155;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h007;
    cycle();
    check("rst_mem_en_ppu", 32'({s_en, s_we, s_addr}), 32'({1'b1, 1'b0, 11'h155}));
    ppu_req = 1'b0; cpu_req = 1'b0;
    cycle();
    check("rst_rvalid_masked", 32'(s_rvalid), 32'(1'b0));
    check("rst_no_cpu_en", 32'(s_en), 32'(1'b0));
    rst = 1'b0;
    mon_en = 1'b1;

    // table-driven PPU vectors
    for (int i = 0; i < 8; i++) begin
      ppu_req = tbl[i].req;
      ppu_addr = tbl[i].addr;
      cycle();
      check("tbl_mem_en", 32'(s_en), 32'(tbl[i].exp_en));
      if (tbl[i].exp_en) check("tbl_mem_addr", 32'({s_we, s_addr}), 32'({1'b0, tbl[i].exp_addr}));
      check("tbl_rvalid", 32'(s_rvalid), 32'(tbl[i].exp_rvalid));
    end

    // PPU fetching every cycle
    for (int i = 0; i < 100; i++) begin
      ppu_req = 1'b1;
      ppu_addr = AW'(i);
      cycle();
      check("stream_addr", 32'(s_addr), 32'(i));
      check("stream_we", 32'(s_we), 32'(1'b0));
      if (i > 0) begin
        check("stream_rvalid", 32'(s_rvalid), 32'(1'b1));
        check("stream_rdata", 32'(s_prdata), 32'(init_val(AW'(i - 1))));
      end
    end
    ppu_req = 1'b0;
    cycle();
    check("stream_tail_rvalid", 32'(s_rvalid), 32'(1'b1));
    check("idle_no_mem_en", 32'(s_en), 32'(1'b0));

    // write then read, no PPU traffic
    cpu_op(1'b1, 11'h123, 8'h5A, st, is, ak);
    check("wr_ack_latency", 32'(ak - st), 32'd1);
    check("wr_drain_count", 32'(wlog_addr.size()), 32'd1);
    check("wr_drain_addr", 32'(wlog_addr[$]), 32'h123);
    check("wr_drain_data", 32'(wlog_data[$]), 32'h5A);
    check("wr_drain_cycle", 32'(wlog_cyc[$]), 32'(st + 1));
    cpu_op(1'b0, 11'h123, 8'h00, st, is, ak);
    check("rd_value", 32'(s_crdata), 32'h5A);
    check("rd_total_latency", 32'(ak - st), 32'd3);

    // read pending under a 20-cycle PPU burst
    ppu_req = 1'b1;
    ppu_addr = 11'h3C0;
    ppu_mode = 1;
    ppu_hold = 19;
    cpu_op(1'b0, 11'h040, 8'h00, st, is, ak);
    check("burst_len", 32'(last_hi - st + 1), 32'd20);
    check("rd_issue_after_ppu", 32'(is), 32'(last_hi + 1));
    check("rd_burst_value", 32'(s_crdata), 32'hE5);
    ppu_mode = 0;
    ppu_req = 1'b0;

    // back-to-back writes while the PPU holds the port
    ppu_req = 1'b1;
    ppu_addr = 11'h010;
    ppu_mode = 1;
    ppu_hold = 9;
    n0 = wlog_addr.size();
    cpu_op(1'b1, 11'h010, 8'h11, st, is, ak);
    check("wb1_ack_latency", 32'(ak - st), 32'd1);
    cpu_op(1'b1, 11'h011, 8'h22, st2, is, ak2);
    check("wb2_ack_after_drain", 32'(ak2), 32'(last_hi + 3));
    ppu_mode = 0;
    ppu_req = 1'b0;
    cycle();
    check("wb_drain_count", 32'(wlog_addr.size() - n0), 32'd2);
    check("wb_first", 32'({wlog_addr[n0], wlog_data[n0]}), 32'({11'h010, 8'h11}));
    check("wb_second", 32'({wlog_addr[n0 + 1], wlog_data[n0 + 1]}), 32'({11'h011, 8'h22}));
    check("wb_vram_010", 32'(vram[11'h010]), 32'h11);
    check("wb_vram_011", 32'(vram[11'h011]), 32'h22);

    // read right behind a write with the PPU on alternate cycles
    ppu_req = 1'b1;
    ppu_mode = 2;
    cpu_op(1'b1, 11'h200, 8'h77, st, is, ak);
    cpu_op(1'b0, 11'h200, 8'h00, st, is, ak);
    check("raw_value", 32'(s_crdata), 32'h77);
    ppu_mode = 0;
    ppu_req = 1'b0;

    // reset while the read is in its data cycle
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h123;
    cycle();
    cycle();
    check("abort_rd_issued", 32'({s_en, s_we, s_addr}), 32'({1'b1, 1'b0, 11'h123}));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cpu_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("abort_no_ack", 32'(s_ack), 32'(1'b0));
      check("abort_rdata_cleared", 32'(s_crdata), 32'h0);
      check("abort_no_mem_en", 32'(s_en), 32'(1'b0));
    end
    cpu_op(1'b1, 11'h124, 8'h33, st, is, ak);
    check("abort_idle_wr_latency", 32'(ak - st), 32'd1);

    // reset discards a buffered write
    ppu_req = 1'b1;
    ppu_addr = 11'h050;
    ppu_mode = 1;
    ppu_hold = 5;
    cpu_op(1'b1, 11'h300, 8'h99, st, is, ak);
    n0 = wlog_addr.size();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ppu_mode = 0;
    ppu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("discard_no_mem_en", 32'(s_en), 32'(1'b0));
    end
    check("discard_no_write", 32'(wlog_addr.size() - n0), 32'd0);
    check("discard_vram", 32'(vram[11'h300]), 32'(init_val(11'h300)));
    ref_mem[11'h300] = init_val(11'h300);  // the write never reached VRAM

    // randomized CPU traffic against random PPU fetches
    ppu_mode = 3;
    ppu_pct = 40;
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom_range(0, 1));
      ra = AW'(11'h380 + AW'($urandom_range(0, 7)));
      rd = DW'($urandom_range(0, 255));
      cpu_op(rw, ra, rd, st, is, ak);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) cycle();
    end
    ppu_mode = 0;
    ppu_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 8; i++) begin
      check("final_vram", 32'(vram[11'h380 + AW'(i)]), 32'(ref_mem[11'h380 + AW'(i)]));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
